// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// state_t is the transmit sequencer state; GAP is only reachable when the
// design is built with TX_GAP_EN.
package uart_pkg;

    // Default TX FIFO entry count.
    localparam int TX_FIFO_DEPTH = 8;

    // Width of one transmitted character.
    localparam int TX_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO holding bytes queued for transmission.
// Status (full/empty/level) comes from the registered count only, so a push
// arriving while full is dropped even if a pop happens on the same edge.
// Overflow is sticky until flush or reset. Flush wins over a simultaneous
// push; a pop on the flush edge still returns the head entry to the caller.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = TX_FIFO_DEPTH,
    parameter int WIDTH = TX_DATA_W
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o     = (count_q == CW'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign level_o    = count_q;
    assign overflow_o = overflow_q;
    assign head_o     = mem_q[rd_ptr_q];

    assign push_ok = push_i && !full_o && !flush_i;
    assign pop_ok  = pop_i && !empty_o;

    // Next pointer/count/overflow values; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (flush_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (push_i && full_o) begin
                overflow_d = 1'b1;
            end
        end
    end

    // Control registers of the FIFO.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage array; left unreset so it maps onto RAM.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/tx_sequencer.sv
// Transmit sequencer: queues bytes in a FIFO and hands them one at a time
// to the transmit frontend (transmit_o pulse + dr_o), waiting for done_i
// between frames.
// Optional feature macro TX_GAP_EN: adds port cr_gap_i and a GAP state that
// idles for cr_gap_i cycles after each done_i before the next frame.
module tx_sequencer
    import uart_pkg::*;
#(
    parameter int DEPTH = TX_FIFO_DEPTH
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic [7:0]             push_data_i,
    input  logic                   flush_i,
`ifdef TX_GAP_EN
    input  logic [15:0]            cr_gap_i,
`endif
    input  logic                   done_i,
    output logic                   transmit_o,
    output logic [7:0]             dr_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic                   busy_o,
    output logic                   overflow_o,
    output logic [$clog2(DEPTH):0] level_o
);

    state_t      state_q, state_d;
    logic        transmit_q, transmit_d;
    logic [7:0]  dr_q, dr_d;
    logic        pop;
    logic [7:0]  fifo_head;
`ifdef TX_GAP_EN
    logic [15:0] gap_cnt_q, gap_cnt_d;
`endif

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (TX_DATA_W)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push_i),
        .push_data_i (push_data_i),
        .pop_i       (pop),
        .flush_i     (flush_i),
        .head_o      (fifo_head),
        .full_o      (full_o),
        .empty_o     (empty_o),
        .level_o     (level_o),
        .overflow_o  (overflow_o)
    );

    assign transmit_o = transmit_q;
    assign dr_o       = dr_q;
    assign busy_o     = (state_q != IDLE);

    // Next-state logic; the head byte is popped into dr on IDLE->ISSUE and
    // held there until the frame completes (flush does not disturb it).
    always_comb begin
        state_d    = state_q;
        transmit_d = 1'b0;
        dr_d       = dr_q;
        pop        = 1'b0;
`ifdef TX_GAP_EN
        gap_cnt_d  = gap_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (!empty_o) begin
                    state_d    = ISSUE;
                    transmit_d = 1'b1;
                    dr_d       = fifo_head;
                    pop        = 1'b1;
                end
            end
            ISSUE: begin
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (done_i) begin
`ifdef TX_GAP_EN
                    if (cr_gap_i != 16'd0) begin
                        state_d   = GAP;
                        gap_cnt_d = cr_gap_i - 16'd1;
                    end else begin
                        state_d = IDLE;
                    end
`else
                    state_d = IDLE;
`endif
                end
            end
`ifdef TX_GAP_EN
            GAP: begin
                if (gap_cnt_q == 16'd0) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 16'd1;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer registers; reset drops any frame in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            transmit_q <= 1'b0;
            dr_q       <= 8'd0;
`ifdef TX_GAP_EN
            gap_cnt_q  <= 16'd0;
`endif
        end else begin
            state_q    <= state_d;
            transmit_q <= transmit_d;
            dr_q       <= dr_d;
`ifdef TX_GAP_EN
            gap_cnt_q  <= gap_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_tx_sequencer.sv
// Self-checking bench for tx_sequencer (DEPTH=8). Directed scenarios plus a
// randomized run against a timeline/queue reference model. Build with
// TX_GAP_EN defined to include the inter-frame gap scenario.
module tb_tx_sequencer;

    localparam int DEPTH = 8;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        push_i = 1'b0;
    logic [7:0]  push_data_i = 8'd0;
    logic        flush_i = 1'b0;
    logic        done_i = 1'b0;
`ifdef TX_GAP_EN
    logic [15:0] cr_gap_i = 16'd0;
`endif
    logic        transmit_o;
    logic [7:0]  dr_o;
    logic        full_o, empty_o, busy_o, overflow_o;
    logic [3:0]  level_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk_i = ~clk_i;

    tx_sequencer #(.DEPTH(DEPTH)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push_i),
        .push_data_i (push_data_i),
        .flush_i     (flush_i),
`ifdef TX_GAP_EN
        .cr_gap_i    (cr_gap_i),
`endif
        .done_i      (done_i),
        .transmit_o  (transmit_o),
        .dr_o        (dr_o),
        .full_o      (full_o),
        .empty_o     (empty_o),
        .busy_o      (busy_o),
        .overflow_o  (overflow_o),
        .level_o     (level_o)
    );

    // Reference model: a byte queue plus a frame timeline expressed in cycle
    // indices (next cycle a pop may happen, first cycle done_i counts).
    logic [7:0] m_q[$];
    bit         m_inflight = 0;
    int         m_next_pop = 0;
    int         m_done_ok = 0;
    logic [7:0] m_dr = 8'd0;
    bit         m_tx = 0;
    bit         m_ovf = 0;
    bit         m_busy = 0;

    // Advance one clock: update the model from the inputs of this cycle,
    // then move to just after the next rising edge.
    task automatic tick();
        int c = cyc;
        bit full_now = (m_q.size() == DEPTH);
        int gap_now = 0;
`ifdef TX_GAP_EN
        gap_now = int'(cr_gap_i);
`endif
        m_tx = 0;
        if (rst_i) begin
            m_q.delete();
            m_inflight = 0;
            m_next_pop = 0;
            m_dr = 8'd0;
            m_ovf = 0;
        end else begin
            if (m_inflight && c >= m_done_ok && done_i) begin
                m_inflight = 0;
                m_next_pop = c + 1 + gap_now;
            end else if (!m_inflight && c >= m_next_pop && m_q.size() != 0) begin
                m_dr = m_q.pop_front();
                m_tx = 1;
                m_inflight = 1;
                m_done_ok = c + 2;
            end
            if (flush_i) begin
                m_q.delete();
                m_ovf = 0;
            end else if (push_i) begin
                if (full_now) m_ovf = 1;
                else m_q.push_back(push_data_i);
            end
        end
        m_busy = m_inflight || (c + 1 < m_next_pop);
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        push_i = 0; flush_i = 0; done_i = 0; rst_i = 1;
        tick(); tick();
        rst_i = 0;
    endtask

    task automatic test_reset();
        push_i = 0; flush_i = 0; done_i = 0; rst_i = 1;
        tick(); tick();
        checks++; if (transmit_o !== 1'b0) begin errors++; $display("FAIL reset_transmit got %0b want 0", transmit_o); end
        checks++; if (dr_o !== 8'h00) begin errors++; $display("FAIL reset_dr got %h want 00", dr_o); end
        checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL reset_empty got %0b want 1", empty_o); end
        checks++; if (full_o !== 1'b0) begin errors++; $display("FAIL reset_full got %0b want 0", full_o); end
        checks++; if (level_o !== 4'd0) begin errors++; $display("FAIL reset_level got %0d want 0", level_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy_o); end
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0b want 0", overflow_o); end
        rst_i = 0;
        $display("test_reset done at cycle %0d", cyc);
    endtask

    task automatic test_single();
        do_reset();
        push_i = 1; push_data_i = 8'hA5;
        tick();
        push_i = 0;
        checks++; if (transmit_o !== 1'b0) begin errors++; $display("FAIL single_n1_tx got %0b want 0", transmit_o); end
        tick();
        checks++; if (transmit_o !== 1'b1) begin errors++; $display("FAIL single_n2_tx got %0b want 1", transmit_o); end
        checks++; if (dr_o !== 8'hA5) begin errors++; $display("FAIL single_dr got %h want a5", dr_o); end
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL single_busy got %0b want 1", busy_o); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (transmit_o !== 1'b0 || busy_o !== 1'b1 || dr_o !== 8'hA5) begin
                errors++; $display("FAIL single_hold tx %0b busy %0b dr %h want 0 1 a5", transmit_o, busy_o, dr_o);
            end
        end
        done_i = 1; tick(); done_i = 0;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL single_idle busy got %0b want 0", busy_o); end
        checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL single_empty got %0b want 1", empty_o); end
        $display("test_single: byte a5 framed, idle at cycle %0d", cyc);
    endtask

    task automatic test_back_to_back();
        int n = 0;
        int exp_at = -1;
        int last_tx = 0;
        do_reset();
        exp_at = cyc + 2;
        for (int k = 0; k < 40 && n < 3; k++) begin
            push_i = (k < 3);
            push_data_i = 8'(k + 1);
            done_i = (n > 0 && cyc == last_tx + 3);
            if (done_i) exp_at = cyc + 2;
            tick();
            if (transmit_o === 1'b1) begin
                checks++;
                if (dr_o !== 8'(n + 1) || cyc != exp_at) begin
                    errors++; $display("FAIL b2b_frame%0d dr %h at cycle %0d want %h at %0d", n, dr_o, cyc, 8'(n + 1), exp_at);
                end
                $display("b2b frame %0d dr %h cycle %0d", n, dr_o, cyc);
                n++;
                last_tx = cyc;
            end
        end
        push_i = 0; done_i = 0;
        checks++; if (n != 3) begin errors++; $display("FAIL b2b_count got %0d frames want 3", n); end
        tick(); tick(); done_i = 1; tick(); done_i = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (transmit_o !== 1'b0) begin errors++; $display("FAIL b2b_extra_tx got 1 want 0"); end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] got[$];
        do_reset();
        for (int k = 0; k < 9; k++) begin
            push_i = 1; push_data_i = 8'(8'h10 + k);
            tick();
            if (transmit_o === 1'b1) got.push_back(dr_o);
        end
        push_data_i = 8'hFF;
        tick();
        push_i = 0;
        checks++; if (full_o !== 1'b1) begin errors++; $display("FAIL ovf_full got %0b want 1", full_o); end
        checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0b want 1", overflow_o); end
        checks++; if (level_o !== 4'd8) begin errors++; $display("FAIL ovf_level got %0d want 8", level_o); end
        // done frees the sequencer; the following pop edge also sees a push
        // while still full, which must be dropped
        done_i = 1; tick(); done_i = 0;
        push_i = 1; push_data_i = 8'hEE;
        tick();
        push_i = 0;
        if (transmit_o === 1'b1) got.push_back(dr_o);
        checks++; if (level_o !== 4'd7) begin errors++; $display("FAIL ovf_pop_push level got %0d want 7", level_o); end
        done_i = 1;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (transmit_o === 1'b1) got.push_back(dr_o);
        end
        done_i = 0;
        checks++; if (got.size() != 9) begin errors++; $display("FAIL ovf_frames got %0d want 9", got.size()); end
        for (int i = 0; i < got.size() && i < 9; i++) begin
            checks++;
            if (got[i] !== 8'(8'h10 + i)) begin errors++; $display("FAIL ovf_order idx %0d got %h want %h", i, got[i], 8'(8'h10 + i)); end
        end
        checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0b want 1", overflow_o); end
        flush_i = 1; tick(); flush_i = 0;
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL ovf_flush_clear got %0b want 0", overflow_o); end
        $display("test_overflow: %0d frames drained", got.size());
    endtask

    task automatic test_flush();
        int extra = 0;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            push_i = 1; push_data_i = 8'(8'h31 + k);
            tick();
        end
        push_i = 0;
        tick(); tick();
        checks++; if (level_o !== 4'd3) begin errors++; $display("FAIL flush_pre_level got %0d want 3", level_o); end
        flush_i = 1; tick(); flush_i = 0;
        checks++; if (level_o !== 4'd0) begin errors++; $display("FAIL flush_level got %0d want 0", level_o); end
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL flush_ovf got %0b want 0", overflow_o); end
        checks++; if (dr_o !== 8'h31) begin errors++; $display("FAIL flush_dr_hold got %h want 31", dr_o); end
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL flush_busy got %0b want 1", busy_o); end
        done_i = 1; tick(); done_i = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (transmit_o === 1'b1) extra++;
        end
        checks++; if (extra != 0) begin errors++; $display("FAIL flush_no_tx got %0d pulses want 0", extra); end
        $display("test_flush: queue cleared mid-frame at cycle %0d", cyc);
    endtask

`ifdef TX_GAP_EN
    task automatic test_gap();
        int m;
        do_reset();
        cr_gap_i = 16'd5;
        push_i = 1; push_data_i = 8'h51; tick();
        push_data_i = 8'h52; tick();
        push_i = 0;
        tick(); tick();
        m = cyc;
        done_i = 1; tick(); done_i = 0;
        for (int i = 1; i <= 7; i++) begin
            if (i > 1) tick();
            checks++;
            if (transmit_o !== (i == 7) || busy_o !== (i != 6)) begin
                errors++; $display("FAIL gap_cycle%0d tx %0b busy %0b want %0b %0b", i, transmit_o, busy_o, (i == 7), (i != 6));
            end
        end
        checks++; if (dr_o !== 8'h52) begin errors++; $display("FAIL gap_dr got %h want 52", dr_o); end
        $display("test_gap: done at %0d, second frame at %0d", m, cyc);
        tick(); done_i = 1; tick(); done_i = 0;
        cr_gap_i = 16'd0;
        for (int i = 0; i < 8; i++) tick();
    endtask
`endif

    task automatic test_reset_mid_frame();
        int extra = 0;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            push_i = 1; push_data_i = 8'(8'h41 + k);
            tick();
        end
        push_i = 0;
        tick(); tick();
        rst_i = 1; tick();
        checks++;
        if (transmit_o !== 1'b0 || dr_o !== 8'h00 || empty_o !== 1'b1 || full_o !== 1'b0 ||
            level_o !== 4'd0 || busy_o !== 1'b0 || overflow_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid outputs tx %0b dr %h empty %0b full %0b level %0d busy %0b ovf %0b want 0 00 1 0 0 0 0",
                     transmit_o, dr_o, empty_o, full_o, level_o, busy_o, overflow_o);
        end
        rst_i = 0;
        done_i = 1; tick(); done_i = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (transmit_o === 1'b1) extra++;
        end
        checks++; if (extra != 0) begin errors++; $display("FAIL rst_mid_no_tx got %0d pulses want 0", extra); end
        $display("test_reset_mid_frame: done at cycle %0d", cyc);
    endtask

    task automatic test_random();
        logic [3:0] exp_lvl;
        int frames = 0;
        do_reset();
`ifdef TX_GAP_EN
        cr_gap_i = 16'($urandom_range(0, 3));
`endif
        for (int i = 0; i < 400; i++) begin
            push_i = ($urandom_range(0, 2) == 0);
            push_data_i = 8'($urandom);
            done_i = ($urandom_range(0, 3) == 0);
            flush_i = ($urandom_range(0, 39) == 0);
            tick();
            exp_lvl = 4'(m_q.size());
            if (m_tx) frames++;
            checks++; if (transmit_o !== m_tx) begin errors++; $display("FAIL rand_tx cycle %0d got %0b want %0b", cyc, transmit_o, m_tx); end
            checks++; if (dr_o !== m_dr) begin errors++; $display("FAIL rand_dr cycle %0d got %h want %h", cyc, dr_o, m_dr); end
            checks++; if (level_o !== exp_lvl) begin errors++; $display("FAIL rand_level cycle %0d got %0d want %0d", cyc, level_o, exp_lvl); end
            checks++; if (full_o !== (exp_lvl == 4'd8)) begin errors++; $display("FAIL rand_full cycle %0d got %0b", cyc, full_o); end
            checks++; if (empty_o !== (exp_lvl == 4'd0)) begin errors++; $display("FAIL rand_empty cycle %0d got %0b", cyc, empty_o); end
            checks++; if (busy_o !== m_busy) begin errors++; $display("FAIL rand_busy cycle %0d got %0b want %0b", cyc, busy_o, m_busy); end
            checks++; if (overflow_o !== m_ovf) begin errors++; $display("FAIL rand_ovf cycle %0d got %0b want %0b", cyc, overflow_o, m_ovf); end
        end
        push_i = 0; done_i = 0; flush_i = 0;
`ifdef TX_GAP_EN
        cr_gap_i = 16'd0;
`endif
        $display("test_random: %0d frames modelled over 400 cycles", frames);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_flush();
`ifdef TX_GAP_EN
        test_gap();
`endif
        test_reset_mid_frame();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tx_sequencer.md
TX_SEQUENCER -- requirements
Module: tx_sequencer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, giving the TX FIFO entry count (power of two, 2..256).
REQ-002 The block SHALL have port clk_i  input  1  the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port push_i  input  1  write request for one byte.
REQ-005 The block SHALL have port push_data_i  input  8  byte to enqueue.
REQ-006 The block SHALL have port flush_i  input  1  clears the FIFO and the overflow flag.
REQ-007 The block SHALL have port cr_gap_i  input  16  inter-frame idle gap in clk cycles; present only with TX_GAP_EN.
REQ-008 The block SHALL have port done_i  input  1  end-of-frame pulse from the transmit frontend.
REQ-009 The block SHALL have port transmit_o  output  1  one-cycle frame start to the frontend.
REQ-010 The block SHALL have port dr_o  output  8  byte to transmit, to the frontend.
REQ-011 The block SHALL have status ports full_o, empty_o, busy_o and overflow_o  output  1 each.
REQ-012 The block SHALL have port level_o  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-013 The FIFO SHALL be first-in first-out, with push accepted when push_i=1 and full_o=0.
REQ-014 full_o, empty_o and level_o SHALL be derived from the registered count only.
REQ-015 A push while full_o=1 SHALL be dropped, leave the FIFO unchanged and set overflow_o, which is sticky until flush_i or reset.
REQ-016 The state machine SHALL have the states IDLE, ISSUE, WAIT_DONE and GAP.
REQ-017 IDLE SHALL go to ISSUE when empty_o=0; on that edge the head entry is popped into a dr_o register.
REQ-018 ISSUE SHALL assert transmit_o for exactly one cycle, then go to WAIT_DONE.
REQ-019 dr_o SHALL stay stable from ISSUE until the state leaves WAIT_DONE.
REQ-020 WAIT_DONE SHALL wait for done_i=1, then go to GAP (if TX_GAP_EN and cr_gap_i!=0) or else to IDLE.
REQ-021 done_i outside WAIT_DONE SHALL be ignored.
REQ-022 When a byte is pushed into an empty FIFO in IDLE at cycle N, transmit_o SHALL be 1 at cycle N+2.
REQ-023 Back-to-back frames SHALL have transmit_o asserted 2 cycles after done_i when no gap is applied.
REQ-024 A push and a pop in the same cycle SHALL leave level_o unchanged.
REQ-025 A push into a full FIFO in the pop cycle SHALL still be dropped (count is registered).
REQ-026 flush_i SHALL empty the FIFO and clear overflow_o next cycle, and SHALL NOT abort a frame in ISSUE/WAIT_DONE/GAP.
REQ-027 flush_i wins over a simultaneous push.
REQ-028 busy_o SHALL be 1 whenever the state is not IDLE.
REQ-029 Read/write pointers SHALL wrap modulo DEPTH.

Reset
REQ-030 On rst_i the state SHALL become IDLE and the FIFO SHALL be emptied.
REQ-031 Output reset values SHALL be: transmit_o=0, dr_o=0, empty_o=1, full_o=0, level_o=0, busy_o=0, overflow_o=0, gap counter=0.
REQ-032 Reset mid-frame SHALL discard the in-flight byte with no later transmit_o for it.

Configuration
REQ-033 With TX_GAP_EN defined, GAP SHALL load cr_gap_i-1 on entry, decrement each cycle and go to IDLE when it reaches 0, giving exactly cr_gap_i cycles in GAP.
REQ-034 Without TX_GAP_EN, port cr_gap_i and the GAP state logic SHALL be absent and WAIT_DONE SHALL always go to IDLE.

Structure
REQ-035 The state typedef (state_t) SHALL be in shared package uart_pkg.
REQ-036 The default FIFO depth constant (TX_FIFO_DEPTH=8) SHALL be in shared package uart_pkg.
REQ-037 Storage SHALL be one sub-module, sync_fifo (DEPTH, WIDTH=8), instantiated once.

Verification
REQ-038 The bench SHALL push 0xA5 at cycle N when idle -> transmit_o=1 at N+2 with dr_o=0xA5, busy_o=1 until done_i, then IDLE.
REQ-039 The bench SHALL push 0x01,0x02,0x03 and pulse done_i per frame -> transmit_o pulses carry 0x01,0x02,0x03 in order, each 2 cycles after the prior done_i.
REQ-040 The bench SHALL fill to DEPTH=8 with no done_i, then push 0xFF -> full_o=1, overflow_o=1, level_o=8, and 0xFF is never transmitted.
REQ-041 The bench SHALL assert flush_i during WAIT_DONE with 3 queued -> level_o=0 and overflow_o=0 next cycle, the current dr_o is held, and no further transmit_o occurs after done_i.
REQ-042 With TX_GAP_EN and cr_gap_i=5, two queued bytes -> exactly 5 GAP cycles after done_i, with transmit_o 7 cycles after done_i.
REQ-043 The bench SHALL assert rst_i in WAIT_DONE -> every output at its reset value next cycle, and queued data is never sent.
